// File: rtl/pipe_reg_chain_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg_chain_if
//  Description : Handshake bundle for pipe_reg_chain. It carries the
//                producer-side valid/data/ready, the consumer-side
//                valid/data/ready, and the registered occupancy count.
//                - master : producer/consumer side (testbench or wrapper)
//                - slave  : the register chain itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_reg_chain_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNTW-1:0]  count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface
`default_nettype wire

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg_chain
//  Description : DEPTH-stage ready/valid register chain for WIDTH-bit words.
//                Each stage has its own valid bit, so empty stages always
//                accept and bubbles collapse even under back-pressure.
//                A synchronous flush drops all in-flight words.
//  Ports       : clk   - rising-edge clock
//                rst_n - synchronous active-low reset (clears data too)
//                flush - synchronous clear of all valid bits
//                bus   - pipe_reg_chain_if.slave: in_valid/in_data/in_ready,
//                        out_valid/out_data/out_ready, count (occupancy)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  pipe_reg_chain_if.slave      bus
);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [CNTW-1:0]  r_count;

  logic [DEPTH-1:0] w_ready;
  logic             w_acc;
  logic [WIDTH-1:0] w_src_data [DEPTH];
  logic [DEPTH-1:0] w_src_valid;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Stage i may load when it is empty or everything downstream of it moves.
  // Expressed as a running OR from the output end so no bit of w_ready is
  // computed from another bit of the same vector.
  always_comb begin
    w_ready = '0;
    w_acc   = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_acc      = w_acc || !r_valid[i];
      w_ready[i] = w_acc;
    end
  end

  // Predecessor of each stage: the producer for stage 0, else stage i-1.
  always_comb begin
    w_src_data[0]  = bus.in_data;
    w_src_valid    = '0;
    w_src_valid[0] = bus.in_valid;
    for (int i = 1; i < DEPTH; i++) begin
      w_src_data[i]  = r_data[i-1];
      w_src_valid[i] = r_valid[i-1];
    end
  end

  // Gating with rst_n keeps any handshake from completing on a reset edge.
  assign bus.in_ready  = w_ready[0] && !flush && rst_n;
  assign bus.out_valid = r_valid[DEPTH-1] && !flush && rst_n;
  assign bus.out_data  = r_data[DEPTH-1];
  assign bus.count     = r_count;

  assign w_in_xfer  = bus.in_valid && bus.in_ready;
  assign w_out_xfer = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else if (flush) begin
      // Data registers are left as-is; only occupancy is discarded.
      r_valid <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_ready[i]) begin
          r_data[i]  <= w_src_data[i];
          r_valid[i] <= w_src_valid[i];
        end
      end
      r_count <= r_count + CNTW'(w_in_xfer) - CNTW'(w_out_xfer);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_reg_chain
//  Description : Self-checking bench for pipe_reg_chain (WIDTH=8, DEPTH=4).
//                A queue-of-words model (each word carries its stage index)
//                predicts in_ready/out_valid/out_data/count every cycle;
//                directed scenarios add hand-computed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_reg_chain;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_tests = 0;
  int   n_fail  = 0;

  pipe_reg_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Model: words in arrival order, each tagged with its stage position.
  // A word moves forward if the slot ahead is free or the word ahead moves;
  // the oldest word at the last stage leaves when the consumer is ready.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [WIDTH-1:0] d;
    int               pos;
  } word_t;

  word_t q[$];

  always @(negedge clk) begin : model
    bit    mv [DEPTH];
    bit    stuck0;
    bit    exp_ir;
    bit    exp_ov;
    word_t nq[$];
    word_t w;

    stuck0 = 1'b0;
    for (int k = 0; k < DEPTH; k++) mv[k] = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      if (k == 0)
        mv[k] = (q[k].pos == DEPTH - 1) ? bus.out_ready : 1'b1;
      else if (q[k-1].pos > q[k].pos + 1)
        mv[k] = 1'b1;
      else
        mv[k] = mv[k-1];
      if (q[k].pos == 0 && !mv[k]) stuck0 = 1'b1;
    end
    exp_ir = rst_n && !flush && !stuck0;
    exp_ov = rst_n && !flush && (q.size() > 0) && (q[0].pos == DEPTH - 1);

    chk("model_in_ready", 32'(bus.in_ready), 32'(exp_ir));
    chk("model_out_valid", 32'(bus.out_valid), 32'(exp_ov));
    chk("model_count", 32'(bus.count), 32'(q.size()));
    if (exp_ov) chk("model_out_data", 32'(bus.out_data), 32'(q[0].d));

    nq.delete();
    if (rst_n && !flush) begin
      for (int k = 0; k < q.size(); k++) begin
        w = q[k];
        if (mv[k]) begin
          if (w.pos != DEPTH - 1) begin
            w.pos = w.pos + 1;
            nq.push_back(w);
          end
        end else begin
          nq.push_back(w);
        end
      end
      if (bus.in_valid && exp_ir) begin
        w.d   = bus.in_data;
        w.pos = 0;
        nq.push_back(w);
      end
    end
    q = nq;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- Reset ----
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5A;
    bus.out_ready = 1'b1;
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_count", 32'(bus.count), 0);
    step();
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 1);

    // ---- Streaming 0x01..0x08 ----
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      bus.in_valid = (k <= 8);
      bus.in_data  = 8'(k);
      step();
      chk("stream_out_valid", 32'(bus.out_valid), 32'(k >= 4 && k <= 11));
      if (k >= 4 && k <= 11) chk("stream_out_data", 32'(bus.out_data), 32'(k - 3));
      chk("stream_count", 32'(bus.count), 32'((k <= 8) ? ((k < 4) ? k : 4) : 12 - k));
    end

    // ---- Back-pressure 0xA0..0xA5 ----
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus.in_data = 8'(8'hA0 + j);
      #1;
      chk("bp_in_ready_fill", 32'(bus.in_ready), 1);
      step();
    end
    bus.in_data = 8'hA4;
    #1;
    chk("bp_in_ready_full", 32'(bus.in_ready), 0);
    chk("bp_count_full", 32'(bus.count), 4);
    chk("bp_out_valid_full", 32'(bus.out_valid), 1);
    chk("bp_out_data_full", 32'(bus.out_data), 32'h A0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 32'(bus.in_ready), 1);
    for (int j = 0; j < 6; j++) begin
      chk("bp_drain_valid", 32'(bus.out_valid), 1);
      chk("bp_drain_data", 32'(bus.out_data), 32'(8'hA0 + j));
      if (j == 1) bus.in_data = 8'hA5;
      if (j >= 2) bus.in_valid = 1'b0;
      step();
    end
    chk("bp_empty_valid", 32'(bus.out_valid), 0);
    chk("bp_empty_count", 32'(bus.count), 0);

    // ---- Bubble collapse ----
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h11;
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("bub_in_ready_a", 32'(bus.in_ready), 1);
    step();
    chk("bub_in_ready_b", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h22;
    #1;
    chk("bub_in_ready_c", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk("bub_count", 32'(bus.count), 2);
    chk("bub_in_ready", 32'(bus.in_ready), 1);
    chk("bub_out_valid", 32'(bus.out_valid), 1);
    chk("bub_out_data_first", 32'(bus.out_data), 32'h11);
    bus.out_ready = 1'b1;
    step();
    chk("bub_out_valid_second", 32'(bus.out_valid), 1);
    chk("bub_out_data_second", 32'(bus.out_data), 32'h22);
    step();
    chk("bub_out_valid_empty", 32'(bus.out_valid), 0);

    // ---- Flush collision ----
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus.in_data = 8'(8'h40 + j);
      step();
    end
    bus.in_data   = 8'h99;
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    #1;
    chk("fl_in_ready", 32'(bus.in_ready), 0);
    chk("fl_out_valid", 32'(bus.out_valid), 0);
    chk("fl_count_before", 32'(bus.count), 4);
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("fl_count_after", 32'(bus.count), 0);
    chk("fl_out_valid_after", 32'(bus.out_valid), 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h33;
    step();
    bus.in_valid = 1'b0;
    chk("fl_lat_0", 32'(bus.out_valid), 0);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("fl_lat_valid", 32'(bus.out_valid), 32'(j == 2));
    end
    chk("fl_lat_data", 32'(bus.out_data), 32'h33);
    step();

    // ---- Reset mid-operation ----
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus.in_data = 8'(8'h61 + j);
      step();
    end
    chk("mid_count_before", 32'(bus.count), 3);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("mid_out_valid", 32'(bus.out_valid), 0);
    chk("mid_out_data", 32'(bus.out_data), 0);
    chk("mid_count", 32'(bus.count), 0);
    chk("mid_in_ready", 32'(bus.in_ready), 1);
    for (int j = 0; j < 6; j++) begin
      step();
      chk("mid_never_out", 32'(bus.out_valid), 0);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
